// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing constants and per-mode timing bundle.
// Shared by the timing generator and downstream draw stages.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 1024;
  localparam int unsigned H_SYNC_START = 1048;
  localparam int unsigned H_SYNC_STOP  = 1184;
  localparam int unsigned H_TOTAL      = 1344;
  localparam int unsigned V_ACTIVE     = 768;
  localparam int unsigned V_SYNC_START = 771;
  localparam int unsigned V_SYNC_STOP  = 777;
  localparam int unsigned V_TOTAL      = 806;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_sync_start;
    int unsigned h_sync_stop;
    int unsigned h_total;
    int unsigned v_active;
    int unsigned v_sync_start;
    int unsigned v_sync_stop;
    int unsigned v_total;
  } vga_mode_t;

  localparam vga_mode_t MODE_1024X768_60 = '{
    h_active:     H_ACTIVE,
    h_sync_start: H_SYNC_START,
    h_sync_stop:  H_SYNC_STOP,
    h_total:      H_TOTAL,
    v_active:     V_ACTIVE,
    v_sync_start: V_SYNC_START,
    v_sync_stop:  V_SYNC_STOP,
    v_total:      V_TOTAL
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h_active:     800,
    h_sync_start: 840,
    h_sync_stop:  968,
    h_total:      1056,
    v_active:     600,
    v_sync_start: 601,
    v_sync_stop:  605,
    v_total:      628
  };

  function automatic int unsigned frame_pix(vga_mode_t m);
    return m.h_total * m.v_total;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel enable in, timing bundle out.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 16
);

  logic             ce;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             sol;
  logic             sof;

  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("FRAME_W must be at least 1");
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, sol, sof, frame_cnt
  );

  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync,
    input  hblnk, vblnk, sol, sof, frame_cnt
  );
`else
  modport master (
    input  ce,
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, sol, sof
  );

  modport slave (
    output ce,
    input  hcount, vcount, hsync, vsync,
    input  hblnk, vblnk, sol, sof
  );
`endif

endinterface

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis; counter with registered sync/blank
// decoded from the next count so they stay coherent with it.
module vga_axis_cnt #(
  parameter int   W          = 11,
  parameter int   TOTAL      = 1344,
  parameter int   ACTIVE     = 1024,
  parameter int   SYNC_START = 1048,
  parameter int   SYNC_STOP  = 1184,
  parameter logic POL        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         blnk,
  output logic         wrap
);

  // One extra bit so SYNC_STOP == TOTAL == 2^W still compares correctly.
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W:0]   ACT  = (W+1)'(ACTIVE);
  localparam logic [W:0]   SS   = (W+1)'(SYNC_START);
  localparam logic [W:0]   SP   = (W+1)'(SYNC_STOP);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         blnk_q, blnk_d;
  logic [W:0]   ext;

  always_comb begin
    wrap    = inc && (count_q == LAST);
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    ext    = {1'b0, count_d};
    sync_d = (ext >= SS && ext < SP) ? POL : ~POL;
    blnk_d = (ext >= ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing; h/v axes plus sol/sof pulses.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE     = MODE_1024X768_60.h_active,
  parameter int   H_SYNC_START = MODE_1024X768_60.h_sync_start,
  parameter int   H_SYNC_STOP  = MODE_1024X768_60.h_sync_stop,
  parameter int   H_TOTAL      = MODE_1024X768_60.h_total,
  parameter int   V_ACTIVE     = MODE_1024X768_60.v_active,
  parameter int   V_SYNC_START = MODE_1024X768_60.v_sync_start,
  parameter int   V_SYNC_STOP  = MODE_1024X768_60.v_sync_stop,
  parameter int   V_TOTAL      = MODE_1024X768_60.v_total,
  parameter logic H_SYNC_POL   = 1'b1,
  parameter logic V_SYNC_POL   = 1'b1,
  parameter int   CNT_W        = 11,
  parameter int   FRAME_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vif
);

  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_STOP
        && H_SYNC_STOP <= H_TOTAL)) begin : g_bad_h
    $error("horizontal timing out of order");
  end
  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_STOP
        && V_SYNC_STOP <= V_TOTAL)) begin : g_bad_v
    $error("vertical timing out of order");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL)
      || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_w
    $error("CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (FRAME_W < 1) begin : g_bad_fw
    $error("FRAME_W must be at least 1");
  end

  logic h_wrap, v_wrap;
  logic sol_q, sol_d;
  logic sof_q, sof_d;

  vga_axis_cnt #(
    .W(CNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_SYNC_START), .SYNC_STOP(H_SYNC_STOP),
    .POL(H_SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .inc(vif.ce),
    .count(vif.hcount), .sync(vif.hsync),
    .blnk(vif.hblnk), .wrap(h_wrap)
  );

  vga_axis_cnt #(
    .W(CNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_SYNC_START), .SYNC_STOP(V_SYNC_STOP),
    .POL(V_SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .count(vif.vcount), .sync(vif.vsync),
    .blnk(vif.vblnk), .wrap(v_wrap)
  );

  // Pulses reload every clk, so they stay one clk wide under throttled ce.
  always_comb begin
    sol_d = h_wrap;
    sof_d = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sol_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      sol_q <= sol_d;
      sof_q <= sof_d;
    end
  end

  assign vif.sol = sol_q;
  assign vif.sof = sof_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (sof_d) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small modes driven by one random/throttled ce,
// checked against an arithmetic (ce-count based) reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam vga_mode_t MA = '{
    h_active: 24, h_sync_start: 26, h_sync_stop: 30, h_total: 32,
    v_active: 10, v_sync_start: 12, v_sync_stop: 13, v_total: 16
  };
  localparam vga_mode_t MB = '{
    h_active: 8, h_sync_start: 10, h_sync_stop: 12, h_total: 14,
    v_active: 4, v_sync_start: 5, v_sync_stop: 6, v_total: 7
  };
  localparam int FA = 32 * 16;
  localparam int FB = 14 * 7;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic hs, vs, hb, vb, sol, sof;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  int unsigned n = 0;
  bit          pulse = 1'b0;
  int          clk_i = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  snap_t       sa, ea, sb, eb;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(6), .FRAME_W(16)) va ();
  vga_timing_gen_if #(.CNT_W(4), .FRAME_W(2))  vb ();
  assign va.ce = ce;
  assign vb.ce = ce;

  vga_timing_gen #(
    .H_ACTIVE(MA.h_active), .H_SYNC_START(MA.h_sync_start),
    .H_SYNC_STOP(MA.h_sync_stop), .H_TOTAL(MA.h_total),
    .V_ACTIVE(MA.v_active), .V_SYNC_START(MA.v_sync_start),
    .V_SYNC_STOP(MA.v_sync_stop), .V_TOTAL(MA.v_total),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .CNT_W(6), .FRAME_W(16)
  ) dut_a (.clk(clk), .rst(rst), .vif(va));

  vga_timing_gen #(
    .H_ACTIVE(MB.h_active), .H_SYNC_START(MB.h_sync_start),
    .H_SYNC_STOP(MB.h_sync_stop), .H_TOTAL(MB.h_total),
    .V_ACTIVE(MB.v_active), .V_SYNC_START(MB.v_sync_start),
    .V_SYNC_STOP(MB.v_sync_stop), .V_TOTAL(MB.v_total),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CNT_W(4), .FRAME_W(2)
  ) dut_b (.clk(clk), .rst(rst), .vif(vb));

  // n = number of ce updates since reset; p = ce was high on last edge.
  function automatic snap_t model(vga_mode_t m, bit hp, bit vp,
                                  int unsigned cnt, bit p);
    snap_t s;
    int unsigned pos, h, v;
    pos   = cnt % (m.h_total * m.v_total);
    h     = pos % m.h_total;
    v     = pos / m.h_total;
    s.h   = 16'(h);
    s.v   = 16'(v);
    s.hs  = (h >= m.h_sync_start && h < m.h_sync_stop) ? hp : ~hp;
    s.vs  = (v >= m.v_sync_start && v < m.v_sync_stop) ? vp : ~vp;
    s.hb  = (h >= m.h_active);
    s.vb  = (v >= m.v_active);
    s.sol = p && (h == 0);
    s.sof = p && (pos == 0);
    return s;
  endfunction

  function automatic snap_t obs_a();
    snap_t s;
    s = '{h: 16'(va.hcount), v: 16'(va.vcount), hs: va.hsync,
          vs: va.vsync, hb: va.hblnk, vb: va.vblnk,
          sol: va.sol, sof: va.sof};
    return s;
  endfunction

  function automatic snap_t obs_b();
    snap_t s;
    s = '{h: 16'(vb.hcount), v: 16'(vb.vcount), hs: vb.hsync,
          vs: vb.vsync, hb: vb.hblnk, vb: vb.vblnk,
          sol: vb.sol, sof: vb.sof};
    return s;
  endfunction

  task automatic step(input bit c);
    @(negedge clk);
    ce = c;
    @(posedge clk);
    #1;
    clk_i++;
    pulse = c;
    if (c) n++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    sa = obs_a(); ea = model(MA, 1, 1, 0, 0);
    n_chk++;
    if (sa !== ea) begin
      n_fail++;
      $display("FAIL reset_a got %h exp %h", sa, ea);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0; pulse = 0;
    step(1'b0);
    sb = obs_b(); eb = model(MB, 0, 0, n, pulse);
    n_chk++;
    if (sb !== eb) begin
      n_fail++;
      $display("FAIL reset_b got %h exp %h", sb, eb);
    end
    step(1'b1);
    n_chk++;
    if (va.hcount !== 6'd1 || va.sof !== 1'b0 || va.sol !== 1'b0) begin
      n_fail++;
      $display("FAIL first_ce h=%0d sof=%b sol=%b exp h=1 sof=0 sol=0",
               va.hcount, va.sof, va.sol);
    end
  endtask

  task automatic test_free_run();
    int last_sol = -1;
    for (int i = 0; i < 2 * FA; i++) begin
      step(1'b1);
      sa = obs_a(); ea = model(MA, 1, 1, n, pulse);
      sb = obs_b(); eb = model(MB, 0, 0, n, pulse);
      n_chk += 2;
      if (sa !== ea) begin
        n_fail++;
        $display("FAIL free_run_a n=%0d got %h exp %h", n, sa, ea);
      end
      if (sb !== eb) begin
        n_fail++;
        $display("FAIL free_run_b n=%0d got %h exp %h", n, sb, eb);
      end
      if (va.sol === 1'b1) begin
        if (last_sol >= 0) begin
          n_chk++;
          if (clk_i - last_sol != 32) begin
            n_fail++;
            $display("FAIL sol_gap got %0d exp 32", clk_i - last_sol);
          end
        end
        last_sol = clk_i;
      end
    end
  endtask

  task automatic test_throttled();
    int last_sof = -1;
    for (int i = 0; i < 3 * 2 * FA + 3; i++) begin
      step(i % 3 == 0);
      sa = obs_a(); ea = model(MA, 1, 1, n, pulse);
      sb = obs_b(); eb = model(MB, 0, 0, n, pulse);
      n_chk += 2;
      if (sa !== ea) begin
        n_fail++;
        $display("FAIL throttle_a n=%0d got %h exp %h", n, sa, ea);
      end
      if (sb !== eb) begin
        n_fail++;
        $display("FAIL throttle_b n=%0d got %h exp %h", n, sb, eb);
      end
      if (va.sof === 1'b1) begin
        if (last_sof >= 0) begin
          n_chk++;
          if (clk_i - last_sof != 3 * FA) begin
            n_fail++;
            $display("FAIL sof_gap got %0d exp %0d",
                     clk_i - last_sof, 3 * FA);
          end
        end
        last_sof = clk_i;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)));
      sa = obs_a(); ea = model(MA, 1, 1, n, pulse);
      sb = obs_b(); eb = model(MB, 0, 0, n, pulse);
      n_chk += 2;
      if (sa !== ea) begin
        n_fail++;
        $display("FAIL random_a n=%0d got %h exp %h", n, sa, ea);
      end
      if (sb !== eb) begin
        n_fail++;
        $display("FAIL random_b n=%0d got %h exp %h", n, sb, eb);
      end
    end
  endtask

  task automatic test_wrap_corner();
    while ((n % FB) != FB - 1) step(1'b1);
    n_chk++;
    if (vb.hcount !== 4'd13 || vb.vcount !== 4'd6) begin
      n_fail++;
      $display("FAIL corner_pre got (%0d,%0d) exp (13,6)",
               vb.hcount, vb.vcount);
    end
    step(1'b1);
    n_chk++;
    if (vb.hcount !== 4'd0 || vb.vcount !== 4'd0 || vb.hblnk !== 1'b0
        || vb.vblnk !== 1'b0 || vb.sol !== 1'b1 || vb.sof !== 1'b1) begin
      n_fail++;
      $display("FAIL corner got h=%0d v=%0d hb=%b vb=%b sol=%b sof=%b exp 0 0 0 0 1 1",
               vb.hcount, vb.vcount, vb.hblnk, vb.vblnk, vb.sol, vb.sof);
    end
    step(1'b0);
    n_chk++;
    if (vb.sol !== 1'b0 || vb.sof !== 1'b0) begin
      n_fail++;
      $display("FAIL corner_fall sol=%b sof=%b exp 0 0", vb.sol, vb.sof);
    end
  endtask

  task automatic test_mid_reset();
    while ((n % FA) != 9 * 32 + 20) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    n = 0; pulse = 0;
    sa = obs_a(); ea = model(MA, 1, 1, 0, 0);
    sb = obs_b(); eb = model(MB, 0, 0, 0, 0);
    n_chk += 2;
    if (sa !== ea) begin
      n_fail++;
      $display("FAIL async_rst_a got %h exp %h", sa, ea);
    end
    if (sb !== eb) begin
      n_fail++;
      $display("FAIL async_rst_b got %h exp %h", sb, eb);
    end
    @(negedge clk);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sa = obs_a();
    n_chk++;
    if (sa !== ea) begin
      n_fail++;
      $display("FAIL rst_hold got %h exp %h", sa, ea);
    end
    @(negedge clk);
    ce = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < FA + 40; i++) begin
      step(1'b1);
      sa = obs_a(); ea = model(MA, 1, 1, n, pulse);
      sb = obs_b(); eb = model(MB, 0, 0, n, pulse);
      n_chk += 2;
      if (sa !== ea) begin
        n_fail++;
        $display("FAIL restart_a n=%0d got %h exp %h", n, sa, ea);
      end
      if (sb !== eb) begin
        n_fail++;
        $display("FAIL restart_b n=%0d got %h exp %h", n, sb, eb);
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    bit seen_wrap = 1'b0;
    logic [1:0] prev = vb.frame_cnt;
    for (int i = 0; i < 5 * FB; i++) begin
      step(1'($urandom_range(0, 3) != 0));
      n_chk += 2;
      if (va.frame_cnt !== 16'((n / FA) % 65536)) begin
        n_fail++;
        $display("FAIL frame_cnt_a got %0d exp %0d",
                 va.frame_cnt, (n / FA) % 65536);
      end
      if (vb.frame_cnt !== 2'((n / FB) % 4)) begin
        n_fail++;
        $display("FAIL frame_cnt_b got %0d exp %0d",
                 vb.frame_cnt, (n / FB) % 4);
      end
      if (prev == 2'd3 && vb.frame_cnt === 2'd0) seen_wrap = 1'b1;
      prev = vb.frame_cnt;
    end
    n_chk++;
    if (seen_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wrap got no 3->0 exp wrap");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_throttled();
    test_random();
    test_wrap_corner();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator, successor to the fixed 1024x768@60 timing constants in `vga_pkg`. It produces horizontal/vertical counters, sync and blanking signals for any resolution. It also produces start-of-line and start-of-frame pulses and an optional frame counter. It sits at the head of the video pipeline; downstream draw stages (background, terrain, player, point) consume its outputs.

## Interface

Parameters:
- `H_ACTIVE`, 1024: visible pixels per line; also hblank start.
- `H_SYNC_START`, 1048: first pixel of hsync.
- `H_SYNC_STOP`, 1184: first pixel after hsync.
- `H_TOTAL`, 1344: pixels per line; hblank stop.
- `V_ACTIVE`, 768: visible lines; also vblank start.
- `V_SYNC_START`, 771: first line of vsync.
- `V_SYNC_STOP`, 777: first line after vsync.
- `V_TOTAL`, 806: lines per frame; vblank stop.
- `H_SYNC_POL`, 1'b1: hsync asserted level.
- `V_SYNC_POL`, 1'b1: vsync asserted level.
- `CNT_W`, 11: counter width. Must satisfy 2^CNT_W ≥ max(H_TOTAL, V_TOTAL).
- `FRAME_W`, 16: frame counter width.

Ports:
- `clk`, in, 1: system clock (65 MHz for the default mode).
- `rst`, in, 1: asynchronous, active-high reset.
- `ce`, in, 1: pixel clock enable. Counters advance only when high.
- `hcount`, out, CNT_W: current pixel column.
- `vcount`, out, CNT_W: current line.
- `hsync`, out, 1: horizontal sync, at H_SYNC_POL when asserted.
- `vsync`, out, 1: vertical sync, at V_SYNC_POL when asserted.
- `hblnk`, out, 1: high when hcount ≥ H_ACTIVE.
- `vblnk`, out, 1: high when vcount ≥ V_ACTIVE.
- `sol`, out, 1: start-of-line pulse.
- `sof`, out, 1: start-of-frame pulse.
- `frame_cnt`, out, FRAME_W: completed-frame count. Present only with `VGA_FRAME_CNT_EN`.

## Operation

- `hcount` counts 0..H_TOTAL-1 and wraps to 0.
- On each hcount wrap, `vcount` increments through 0..V_TOTAL-1 and wraps to 0.
- All updates are qualified by `ce`. With `ce` low, counters, syncs and blanks hold.
- Decode is half-open and evaluated on the next count value, so decodes are coherent with the counts in the same cycle:
  - hsync asserted for hcount in [H_SYNC_START, H_SYNC_STOP).
  - vsync asserted for vcount in [V_SYNC_START, V_SYNC_STOP).
  - hblnk covers [H_ACTIVE, H_TOTAL); vblnk covers [V_ACTIVE, V_TOTAL).
- `sol` is high for exactly one `clk` cycle on the update that takes hcount to 0.
- `sof` is high for exactly one `clk` cycle on the update that takes (hcount, vcount) to (0, 0). `sol` is also high on that cycle.
- There is no explicit FSM. The only state is the (hcount, vcount) lattice plus the pulse registers.
- Elaboration asserts, error on violation:
  - H_ACTIVE < H_SYNC_START < H_SYNC_STOP ≤ H_TOTAL.
  - The vertical equivalent of the above.
  - The CNT_W bound.

## Timing

- Every output is a flop. There is no combinational path from `ce` to any output.
- Reset values:
  - hcount = 0, vcount = 0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - hblnk = 0, vblnk = 0.
  - sol = 0, sof = 0, frame_cnt = 0.
- The first `ce` after reset moves hcount to 1. The pixel (0, 0) shown at reset release is not flagged by `sof`.
- Latency: sync and blank change in the same cycle as the count they describe.
- Pulses are `clk`-wide, not `ce`-wide. With a throttled `ce` they fall on the following `clk` even if `ce` stays low.
- Reset mid-frame takes effect immediately. All outputs return to reset values and no `sof` is produced on exit.
- Wrap corner: at (H_TOTAL-1, V_TOTAL-1) followed by `ce`, the next cycle has hcount = 0, vcount = 0, vblnk = 0, hblnk = 0, sol = 1, sof = 1.

## Configuration

- `VGA_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments by 1 in the same cycle `sof` is high.
  - It wraps modulo 2^FRAME_W.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure

- `vga_pkg` holds the default-mode constants: H_ACTIVE, H_SYNC_START, H_SYNC_STOP, H_TOTAL and the vertical equivalents. These replace the HBLANK_*/VBLANK_* names.
- `vga_pkg` also holds a `vga_mode_t` struct bundling one mode's eight timing values, and localparam instances `MODE_1024X768_60` and `MODE_800X600_60`.
- One sub-module, `vga_axis_cnt`, is instantiated twice (horizontal and vertical).
  - Parameters: TOTAL, ACTIVE, SYNC_START, SYNC_STOP, POL.
  - Ports: clk, rst, inc, count, sync, blnk, wrap.

## Test plan

- Default mode, `ce` = 1, run from reset:
  - hsync rises on the cycle hcount = 1048 and falls at 1184.
  - hblnk rises at 1024.
  - 1344 cycles separate consecutive `sol` pulses.
- Default mode, full frame:
  - vsync is high exactly for vcount 771..776.
  - `sof` pulses are 1 083 264 cycles apart.
  - With `VGA_FRAME_CNT_EN`, frame_cnt goes 0→1→2.
- `ce` toggled 1-in-3:
  - Counts advance only on `ce` cycles.
  - `sof` and `sol` remain one `clk` wide.
  - Frame period is 3 249 792 clk.
- Small mode (H 8/10/12/14, V 4/5/6/7, POL = 0):
  - hsync is low for hcount 10..11 and vsync is low for vcount 5.
  - Wrap corner (13, 6) goes to (0, 0) with sol = sof = 1.
- Assert `rst` at hcount = 500, vcount = 400:
  - All outputs return to reset values asynchronously.
  - After release, the counter restarts at 0 with no spurious `sof`.
- FRAME_W = 2 with `VGA_FRAME_CNT_EN`: after 4 frames, frame_cnt wraps 3→0.
